// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load-mode encodings and default widths.
package wb_pkg;

  localparam logic [2:0] LM_WORD   = 3'd0;
  localparam logic [2:0] LM_BYTE_S = 3'd1;
  localparam logic [2:0] LM_BYTE_U = 3'd2;
  localparam logic [2:0] LM_HALF_S = 3'd3;
  localparam logic [2:0] LM_HALF_U = 3'd4;

  localparam int WB_WIDTH  = 32;
  localparam int WB_ADDR_W = 5;

endpackage

// File: rtl/load_extend_m.sv
// Memory-load lane extraction with sign/zero extension and alignment check.
module load_extend_m
  import wb_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       load_mode,
  input  logic [1:0]       byte_offset,
  output logic [WIDTH-1:0] ext_data,
  output logic             misalign
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign half_s = byte_offset[1] ? data[31:16] : data[15:0];

  always_comb begin
    case (byte_offset)
      2'd0:    byte_s = data[7:0];
      2'd1:    byte_s = data[15:8];
      2'd2:    byte_s = data[23:16];
      2'd3:    byte_s = data[31:24];
      default: byte_s = 8'h00;
    endcase
  end

  // Modes 5-7 fall into the word path.
  always_comb begin
    case (load_mode)
      LM_BYTE_S: begin
        ext_data = {{(WIDTH-8){byte_s[7]}}, byte_s};
        misalign = 1'b0;
      end
      LM_BYTE_U: begin
        ext_data = {{(WIDTH-8){1'b0}}, byte_s};
        misalign = 1'b0;
      end
      LM_HALF_S: begin
        ext_data = {{(WIDTH-16){half_s[15]}}, half_s};
        misalign = byte_offset[0];
      end
      LM_HALF_U: begin
        ext_data = {{(WIDTH-16){1'b0}}, half_s};
        misalign = byte_offset[0];
      end
      default: begin
        ext_data = data;
        misalign = (byte_offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/writeback_select_m.sv
// Registered writeback source select (MEM/WB register) driving the register-file write port.
module writeback_select_m
  import wb_pkg::*;
#(
  parameter int WIDTH   = WB_WIDTH,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int MEM_SRC = 1,
  parameter int ADDR_W  = WB_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [SEL_W-1:0]         select,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [2:0]               load_mode,
  input  logic [1:0]               byte_offset,
  input  logic                     reg_write_in,
  input  logic [ADDR_W-1:0]        dest_in,
  output logic                     out_valid,
  output logic                     reg_write_out,
  output logic [ADDR_W-1:0]        dest_out,
  output logic signed [WIDTH-1:0]  wb_data,
  output logic                     misalign,
  output logic                     sel_error
);

  localparam int NUM_SLOTS = 1 << SEL_W;
  localparam logic [SEL_W:0]   NUM_SRC_L = (SEL_W + 1)'(NUM_SRC);
  localparam logic [SEL_W-1:0] MEM_SEL_L = SEL_W'(MEM_SRC);

  logic [WIDTH-1:0]  src_slot_s [NUM_SLOTS];
  logic [WIDTH-1:0]  mux_data_s;
  logic [WIDTH-1:0]  ext_data_s;
  logic              ext_misalign_s;
  logic              in_range_s;
  logic              is_mem_s;
  logic              misalign_s;
  logic              we_s;
  logic [WIDTH-1:0]  load_data_s;

  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              misalign_q, misalign_d;
  logic              sel_error_q, sel_error_d;

  // Pad the source list to a power of two so any select value indexes safely.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    if (g < NUM_SRC) begin : g_src
      assign src_slot_s[g] = src_data[g*WIDTH +: WIDTH];
    end else begin : g_pad
      assign src_slot_s[g] = '0;
    end
  end

  assign mux_data_s = src_slot_s[select];
  assign in_range_s = ({1'b0, select} < NUM_SRC_L);
  assign is_mem_s   = (select == MEM_SEL_L);

  load_extend_m #(.WIDTH(WIDTH)) u_load_extend (
    .data        (src_data[MEM_SRC*WIDTH +: WIDTH]),
    .load_mode   (load_mode),
    .byte_offset (byte_offset),
    .ext_data    (ext_data_s),
    .misalign    (ext_misalign_s)
  );

  assign misalign_s  = is_mem_s & ext_misalign_s;
  assign we_s        = in_valid & reg_write_in & (dest_in != '0) & ~misalign_s & in_range_s;
  assign load_data_s = !in_range_s ? '0 :
                       is_mem_s    ? (misalign_s ? '0 : ext_data_s) :
                                     mux_data_s;

  // Next-state: flush beats stall beats load; sel_error survives flush.
  always_comb begin
    valid_d     = valid_q;
    we_d        = we_q;
    dest_d      = dest_q;
    data_d      = data_q;
    misalign_d  = misalign_q;
    sel_error_d = sel_error_q;
    if (flush) begin
      valid_d    = 1'b0;
      we_d       = 1'b0;
      dest_d     = '0;
      data_d     = '0;
      misalign_d = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      valid_d     = in_valid;
      we_d        = we_s;
      dest_d      = dest_in;
      data_d      = load_data_s;
      misalign_d  = misalign_s;
      sel_error_d = sel_error_q | (in_valid & ~in_range_s);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      we_q        <= 1'b0;
      dest_q      <= '0;
      data_q      <= '0;
      misalign_q  <= 1'b0;
      sel_error_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      we_q        <= we_d;
      dest_q      <= dest_d;
      data_q      <= data_d;
      misalign_q  <= misalign_d;
      sel_error_q <= sel_error_d;
    end
  end

  assign out_valid     = valid_q;
  assign reg_write_out = we_q;
  assign dest_out      = dest_q;
  assign wb_data       = data_q;
  assign misalign      = misalign_q;
  assign sel_error     = sel_error_q;

endmodule

// File: doc/writeback_select_m.md
Name: writeback_select_m

Overview:
Parametrised, registered successor to the 2-1 writeback multiplexer. It selects one of NUM_SRC result sources, for example the ALU result, memory read data, PC+4 link value or an immediate. For memory loads it extracts and sign- or zero-extends bytes and halfwords. The result is held in a MEM/WB pipeline register with stall and flush control, and the block drives the register-file write port directly.

Parameters:
WIDTH, 32, datapath width in bits; must be at least 32.
NUM_SRC, 4, number of writeback sources; must be at least 2.
SEL_W, $clog2(NUM_SRC), width of the select field (derived; do not override).
MEM_SRC, 1, index of the source that carries memory read data; load extension applies only to this source.
ADDR_W, 5, register-file address width.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous reset, active-low
in_valid  input  1  the upstream MEM stage holds a valid instruction
stall  input  1  hold the WB register contents
flush  input  1  kill the instruction being loaded (bubble)
select  input  SEL_W  source index
src_data  input  NUM_SRC*WIDTH  packed sources; source i is at bits [i*WIDTH +: WIDTH]
load_mode  input  3  0=word, 1=byte signed, 2=byte unsigned, 3=half signed, 4=half unsigned; 5-7 treated as word
byte_offset  input  2  address bits [1:0] of the load
reg_write_in  input  1  the instruction writes a register
dest_in  input  ADDR_W  destination register
out_valid  output  1  the WB register holds a valid instruction
reg_write_out  output  1  register-file write enable
dest_out  output  ADDR_W  register-file write address
wb_data  output  WIDTH (signed)  register-file write data
misalign  output  1  the registered instruction was a misaligned load
sel_error  output  1  sticky; set by an out-of-range select

Behaviour:
- Reset: with reset_n=0 at a rising edge, every output is cleared to 0, including sel_error.
- Latency: exactly 1 cycle from the inputs to the registered outputs. There is no combinational path from the inputs to the outputs.
- Update priority at each edge: reset > flush > stall > load.
- flush: out_valid, reg_write_out and misalign become 0. dest_out and wb_data become 0.
- flush takes priority over a concurrent stall.
- stall without flush: every output holds its value.
- Load: out_valid <= in_valid.
- Load, select not MEM_SRC: wb_data <= src_data[select].
- Load, select == MEM_SRC, word mode: wb_data passes through.
- Load, select == MEM_SRC, byte modes: extract bits [8*byte_offset +: 8].
- Load, select == MEM_SRC, half modes: extract bits [16*byte_offset[1] +: 16].
- Extension: bytes and halfwords are sign- or zero-extended to WIDTH. Bits above 32 (WIDTH>32) are filled by the same extension.
- Misalignment, defined only for select == MEM_SRC:
  - half mode with byte_offset[0]=1, or
  - word mode with byte_offset != 0.
  On misalignment, misalign <= 1, wb_data <= 0 and reg_write_out <= 0.
- Out-of-range select (select >= NUM_SRC, possible only when NUM_SRC is not a power of two):
  - wb_data <= 0 and reg_write_out <= 0;
  - sel_error is set and stays set until reset;
  - the error is recorded only when in_valid=1 and the register actually loads.
- Write enable: reg_write_out <= in_valid & reg_write_in & (dest_in != 0) & no misalign & select in range. Writes to register 0 are always suppressed.
- dest_out <= dest_in on every load, even when the write is suppressed.
- Held values are not re-evaluated. For example, a stall with changing inputs has no effect on the outputs.
- There is no internal state other than the output registers and the sticky sel_error.

Decomposition:
- Shared package wb_pkg:
  - load_mode encodings as localparams LM_WORD, LM_BYTE_S, LM_BYTE_U, LM_HALF_S, LM_HALF_U;
  - default WIDTH and ADDR_W constants.
- One combinational sub-module, load_extend_m. Inputs: data, load_mode, byte_offset. Outputs: extended data and misalign.
- The multiplexing and the pipeline register stay in the top module.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with in_valid=1 and reg_write_in=1 -> all outputs are 0 and sel_error=0. Release reset with select=0, src0=0x00000005, dest_in=3 -> one cycle later wb_data=5, dest_out=3, reg_write_out=1.
2. Load extension, select=MEM_SRC, src1=0x80F1A27F:
   - byte signed, offset 0 -> 0x0000007F;
   - byte signed, offset 2 -> 0xFFFFFFF1;
   - byte unsigned, offset 3 -> 0x00000080;
   - half signed, offset 2 -> 0xFFFF80F1;
   - half unsigned, offset 0 -> 0x0000A27F.
3. Misaligned loads: half signed with offset 1, and word with offset 2 -> misalign=1, wb_data=0, reg_write_out=0, out_valid=1.
4. Stall and flush:
   - load value 0x11 at dest 4, then assert stall for 3 cycles with src0=0x22 -> outputs stay 0x11 / 4;
   - assert stall and flush together -> next cycle out_valid=0 and reg_write_out=0.
5. Zero register: dest_in=0 with reg_write_in=1 and src0=0xDEAD -> reg_write_out=0, dest_out=0, wb_data=0xDEAD.
6. Out-of-range select, NUM_SRC=3:
   - select=3 with in_valid=1 -> wb_data=0, reg_write_out=0, sel_error=1;
   - sel_error remains 1 through further valid traffic and clears only on reset.
